// File: rtl/mem_stream_loader_if.sv
// Stream-in / memory-write bundle for mem_stream_loader.
// The slave side is the loader itself; the master side is whoever drives
// the byte stream and owns the target memory.
interface mem_stream_loader_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 256
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic          start;
  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_ready;
  logic          we;
  logic [AW-1:0] waddr;
  logic [WIDTH-1:0] wdata;
  logic          done;
  logic [CW-1:0] word_count;

  modport master (
    output start, in_data, in_valid,
    input  in_ready, we, waddr, wdata, done, word_count
  );

  modport slave (
    input  start, in_data, in_valid,
    output in_ready, we, waddr, wdata, done, word_count
  );
endinterface

// File: rtl/mem_stream_loader.sv
// Packs an incoming byte stream into WIDTH-bit words and writes them to
// addresses 0..DEPTH-1 of a target memory, one write cycle per word.
module mem_stream_loader #(
  parameter int WIDTH         = 8,
  parameter int DEPTH         = 256,
  parameter int LITTLE_ENDIAN = 1
) (
  input logic clk,
  input logic rst,
  mem_stream_loader_if.slave bus
);
  localparam int BYTES = WIDTH / 8;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int IW    = (BYTES > 1) ? $clog2(BYTES) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  generate
    if ((WIDTH % 8) != 0 || WIDTH < 8) begin : g_width_check
      $error("mem_stream_loader: WIDTH must be a non-zero multiple of 8");
    end
  endgenerate

  state_t          state;
  state_t          state_next;
  logic [AW-1:0]   addr;
  logic [IW-1:0]   byte_idx;
  logic [IW-1:0]   byte_pos;
  logic [CW-1:0]   words;
  logic [WIDTH-1:0] assembly;
  logic            transfer;
  logic            last_byte;
  logic            last_addr;

  assign transfer  = bus.in_valid && (state == LOAD);
  assign last_byte = (byte_idx == IW'(BYTES - 1));
  assign last_addr = (addr == AW'(DEPTH - 1));

  assign bus.in_ready   = (state == LOAD);
  assign bus.we         = (state == WRITE);
  assign bus.done       = (state == DONE);
  assign bus.waddr      = addr;
  assign bus.wdata      = assembly;
  assign bus.word_count = words;

  // Byte lane inside the word for the current byte, honouring endianness.
  always_comb begin
    byte_pos = byte_idx;
    if (LITTLE_ENDIAN == 0) begin
      byte_pos = IW'(BYTES - 1) - byte_idx;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode; start always (re)enters LOAD, even mid-word or mid-write.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = LOAD;
      LOAD:    if (!bus.start && transfer && last_byte) state_next = WRITE;
      WRITE:   begin
        if (bus.start)      state_next = LOAD;
        else if (last_addr) state_next = DONE;
        else                state_next = LOAD;
      end
      DONE:    if (bus.start) state_next = LOAD;
      default: state_next = IDLE;
    endcase
  end

  // Address, byte index, word counter and word assembly; start beats a same-edge byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr     <= '0;
      byte_idx <= '0;
      words    <= '0;
      assembly <= '0;
    end else if (bus.start) begin
      addr     <= '0;
      byte_idx <= '0;
      words    <= '0;
    end else begin
      case (state)
        LOAD: begin
          if (transfer) begin
            assembly[{byte_pos, 3'b000} +: 8] <= bus.in_data;
            if (!last_byte) begin
              byte_idx <= byte_idx + IW'(1);
            end
          end
        end
        WRITE: begin
          words    <= words + CW'(1);
          byte_idx <= '0;
          if (!last_addr) begin
            addr <= addr + AW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end
endmodule
